// File: rtl/dec_exe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// dec_exe_hazard_ctrl
//
// Control for the fetch->decode and decode->execute pipeline registers.
//  - Holds the whole front end while a multi-cycle execute unit is busy.
//  - Squashes wrong-path work for FLUSH_CYCLES cycles after an execute-stage
//    redirect (fetch->decode loads a NOP, decode->execute loads a bubble).
//  - Detects load-use hazards and inserts a single bubble.
//  - Selects decode-side operand forwarding for rs1/rs2.
//  - Keeps saturating stall and flush performance counters.
//
// Parameters
//  FLUSH_CYCLES : squash cycles after an accepted redirect (>= 1)
//  CNT_W        : width of the performance counters
//
// Ports
//  clk, reset                       : clock (rising edge), async active-high reset
//  dec_valid/rs1/rs2/uses_rs1/rs2   : decode-stage instruction operands
//  exe_valid/rd/regw/memr           : execute-stage instruction (D/E register output)
//  exe_busy                         : multi-cycle execute unit still working
//  exe_redirect                     : execute resolved a taken branch/jump
//  mem_rd/mem_regw                  : memory-stage destination
//  if_id_enable/if_id_flush         : fetch->decode register control
//  dec_exe_enable/dec_exe_bubble    : decode->execute register control
//  fwd_rs1_sel/fwd_rs2_sel          : 00 regfile, 01 execute, 10 memory stage
//  stall_cnt/flush_cnt              : saturating performance counters
//
// The register controls are a same-cycle function of the current state and
// the hazard inputs: a load-use stall or redirect must act on the very cycle
// it is detected, so only the state, flush down-counter and performance
// counters are registered.
// ---------------------------------------------------------------------------
module dec_exe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic             dec_uses_rs1,
  input  logic             dec_uses_rs2,
  input  logic             exe_valid,
  input  logic [4:0]       exe_rd,
  input  logic             exe_regw,
  input  logic             exe_memr,
  input  logic             exe_busy,
  input  logic             exe_redirect,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regw,
  output logic             if_id_enable,
  output logic             if_id_flush,
  output logic             dec_exe_enable,
  output logic             dec_exe_bubble,
  output logic [1:0]       fwd_rs1_sel,
  output logic [1:0]       fwd_rs2_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Down-counter wide enough to hold FLUSH_CYCLES-1 (at least one bit).
  localparam int FC_W = (FLUSH_CYCLES > 1) ? ($clog2(FLUSH_CYCLES) + 1) : 1;

  localparam logic [FC_W-1:0]  FC_RELOAD = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [FC_W-1:0]  FC_ONE    = FC_W'(1);
  localparam logic [FC_W-1:0]  FC_ZERO   = {FC_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EXE = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t          state_r;
  state_t          next_state_s;
  logic [FC_W-1:0] flush_ctr_r;
  logic [FC_W-1:0] next_flush_ctr_s;
  logic            in_flush_s;
  logic            load_use_s;
  logic            redirect_acc_s;
  logic            stall_evt_s;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + CNT_W'(1);
    end
    return r;
  endfunction

  // Forwarding source for one operand; execute is younger so it wins, and
  // a load in execute has no result yet so it never forwards from there.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       e_valid,
    input logic       e_regw,
    input logic       e_memr,
    input logic [4:0] e_rd,
    input logic       m_regw,
    input logic [4:0] m_rd
  );
    logic [1:0] r;
    if (e_valid && e_regw && !e_memr && (e_rd != 5'd0) && (e_rd == rs)) begin
      r = FWD_EXE;
    end else if (m_regw && (m_rd != 5'd0) && (m_rd == rs)) begin
      r = FWD_MEM;
    end else begin
      r = FWD_RF;
    end
    return r;
  endfunction

  // Load in execute whose destination the decode instruction reads.
  always_comb begin
    load_use_s = exe_valid && exe_memr && exe_regw && (exe_rd != 5'd0) && dec_valid &&
                 ((dec_uses_rs1 && (dec_rs1 == exe_rd)) ||
                  (dec_uses_rs2 && (dec_rs2 == exe_rd)));
  end

  // Decode current state; BUSY with exe_busy low behaves exactly like RUN.
  always_comb begin
    case (state_r)
      ST_RUN:   in_flush_s = 1'b0;
      ST_BUSY:  in_flush_s = 1'b0;
      ST_FLUSH: in_flush_s = 1'b1;
      default:  in_flush_s = 1'b0;
    endcase
  end

  // Pipeline register controls and next state, in priority busy > redirect > load-use.
  always_comb begin
    if_id_enable     = 1'b0;
    if_id_flush      = 1'b0;
    dec_exe_enable   = 1'b0;
    dec_exe_bubble   = 1'b0;
    redirect_acc_s   = 1'b0;
    next_state_s     = state_r;
    next_flush_ctr_s = flush_ctr_r;
    if (reset) begin
      next_state_s     = ST_RUN;
      next_flush_ctr_s = FC_ZERO;
    end else if (exe_busy) begin
      // Hold everything; any flush in progress is abandoned.
      next_state_s     = ST_BUSY;
      next_flush_ctr_s = FC_ZERO;
    end else if (exe_redirect) begin
      if_id_enable   = 1'b1;
      if_id_flush    = 1'b1;
      dec_exe_enable = 1'b1;
      dec_exe_bubble = 1'b1;
      redirect_acc_s = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        next_state_s     = ST_FLUSH;
        next_flush_ctr_s = FC_RELOAD;
      end else begin
        next_state_s     = ST_RUN;
        next_flush_ctr_s = FC_ZERO;
      end
    end else if (in_flush_s) begin
      if_id_enable   = 1'b1;
      if_id_flush    = 1'b1;
      dec_exe_enable = 1'b1;
      dec_exe_bubble = 1'b1;
      if (flush_ctr_r <= FC_ONE) begin
        next_state_s     = ST_RUN;
        next_flush_ctr_s = FC_ZERO;
      end else begin
        next_state_s     = ST_FLUSH;
        next_flush_ctr_s = flush_ctr_r - FC_ONE;
      end
    end else if (load_use_s) begin
      // Freeze fetch->decode, push a bubble into execute for this cycle only.
      if_id_enable     = 1'b0;
      dec_exe_enable   = 1'b1;
      dec_exe_bubble   = 1'b1;
      next_state_s     = ST_RUN;
      next_flush_ctr_s = FC_ZERO;
    end else begin
      if_id_enable     = 1'b1;
      dec_exe_enable   = 1'b1;
      next_state_s     = ST_RUN;
      next_flush_ctr_s = FC_ZERO;
    end
  end

  // Operand forwarding selects, forced to regfile while in reset.
  always_comb begin
    if (reset) begin
      fwd_rs1_sel = FWD_RF;
      fwd_rs2_sel = FWD_RF;
    end else begin
      fwd_rs1_sel = fwd_sel(dec_rs1, exe_valid, exe_regw, exe_memr, exe_rd, mem_regw, mem_rd);
      fwd_rs2_sel = fwd_sel(dec_rs2, exe_valid, exe_regw, exe_memr, exe_rd, mem_regw, mem_rd);
    end
  end

  // A stall cycle is any cycle the front end does not advance normally.
  always_comb begin
    stall_evt_s = (!if_id_enable) || dec_exe_bubble;
  end

  // State, flush down-counter and performance counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_RUN;
      flush_ctr_r <= FC_ZERO;
      stall_cnt   <= CNT_ZERO;
      flush_cnt   <= CNT_ZERO;
    end else begin
      state_r     <= next_state_s;
      flush_ctr_r <= next_flush_ctr_s;
      if (stall_evt_s) begin
        stall_cnt <= sat_inc(stall_cnt);
      end else begin
        stall_cnt <= stall_cnt;
      end
      if (redirect_acc_s) begin
        flush_cnt <= sat_inc(flush_cnt);
      end else begin
        flush_cnt <= flush_cnt;
      end
    end
  end

endmodule

// File: tb/tb_dec_exe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dec_exe_hazard_ctrl
//
// Bench for dec_exe_hazard_ctrl with FLUSH_CYCLES=2 and CNT_W=4.
// A behavioural model (remaining squash cycles plus two saturating integer
// counters) predicts every output and is compared on each falling edge.
// Directed scenarios also pin key values with hand-computed literals.
// Inputs change 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_dec_exe_hazard_ctrl;

  localparam int FC    = 2;
  localparam int CW    = 4;
  localparam int SAT   = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          dec_valid = 1'b0;
  logic [4:0]    dec_rs1 = 5'd0;
  logic [4:0]    dec_rs2 = 5'd0;
  logic          dec_uses_rs1 = 1'b0;
  logic          dec_uses_rs2 = 1'b0;
  logic          exe_valid = 1'b0;
  logic [4:0]    exe_rd = 5'd0;
  logic          exe_regw = 1'b0;
  logic          exe_memr = 1'b0;
  logic          exe_busy = 1'b0;
  logic          exe_redirect = 1'b0;
  logic [4:0]    mem_rd = 5'd0;
  logic          mem_regw = 1'b0;
  logic          if_id_enable;
  logic          if_id_flush;
  logic          dec_exe_enable;
  logic          dec_exe_bubble;
  logic [1:0]    fwd_rs1_sel;
  logic [1:0]    fwd_rs2_sel;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state: extra squash cycles still owed, and the two counters.
  int m_flush_left = 0;
  int m_stall      = 0;
  int m_flush      = 0;

  dec_exe_hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_uses_rs1(dec_uses_rs1), .dec_uses_rs2(dec_uses_rs2),
    .exe_valid(exe_valid), .exe_rd(exe_rd), .exe_regw(exe_regw), .exe_memr(exe_memr),
    .exe_busy(exe_busy), .exe_redirect(exe_redirect),
    .mem_rd(mem_rd), .mem_regw(mem_regw),
    .if_id_enable(if_id_enable), .if_id_flush(if_id_flush),
    .dec_exe_enable(dec_exe_enable), .dec_exe_bubble(dec_exe_bubble),
    .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic lit(input string name, input int got, input int exp);
    n_cmp = n_cmp + 1;
    if (got != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Which older stage supplies register rs to decode: 1 execute, 2 memory, 0 regfile.
  function automatic int model_fwd(input logic [4:0] rs);
    int src;
    src = 0;
    if (rs != 5'd0) begin
      if (mem_regw && mem_rd == rs) src = 2;
      if (exe_valid && exe_regw && !exe_memr && exe_rd == rs) src = 1;
    end
    return src;
  endfunction

  // Per-cycle model check.
  always @(negedge clk) begin
    int  e_ifen, e_iff, e_dxen, e_bub;
    bit  lu;
    if (reset) begin
      e_ifen = 0; e_iff = 0; e_dxen = 0; e_bub = 0;
      m_flush_left = 0; m_stall = 0; m_flush = 0;
      lit("m_if_id_enable", int'(if_id_enable), e_ifen);
      lit("m_if_id_flush", int'(if_id_flush), e_iff);
      lit("m_dec_exe_enable", int'(dec_exe_enable), e_dxen);
      lit("m_dec_exe_bubble", int'(dec_exe_bubble), e_bub);
      lit("m_fwd1", int'(fwd_rs1_sel), 0);
      lit("m_fwd2", int'(fwd_rs2_sel), 0);
      lit("m_stall_cnt", int'(stall_cnt), 0);
      lit("m_flush_cnt", int'(flush_cnt), 0);
    end else begin
      lu = exe_valid && exe_memr && exe_regw && exe_rd != 5'd0 && dec_valid &&
           ((dec_uses_rs1 && dec_rs1 == exe_rd) || (dec_uses_rs2 && dec_rs2 == exe_rd));
      lit("m_stall_cnt", int'(stall_cnt), m_stall);
      lit("m_flush_cnt", int'(flush_cnt), m_flush);
      if (exe_busy) begin
        e_ifen = 0; e_iff = 0; e_dxen = 0; e_bub = 0;
        m_flush_left = 0;
      end else if (exe_redirect || m_flush_left > 0) begin
        e_ifen = 1; e_iff = 1; e_dxen = 1; e_bub = 1;
        if (exe_redirect) begin
          m_flush_left = FC - 1;
          if (m_flush < SAT) m_flush = m_flush + 1;
        end else begin
          m_flush_left = m_flush_left - 1;
        end
      end else if (lu) begin
        e_ifen = 0; e_iff = 0; e_dxen = 1; e_bub = 1;
      end else begin
        e_ifen = 1; e_iff = 0; e_dxen = 1; e_bub = 0;
      end
      lit("m_if_id_enable", int'(if_id_enable), e_ifen);
      lit("m_if_id_flush", int'(if_id_flush), e_iff);
      lit("m_dec_exe_enable", int'(dec_exe_enable), e_dxen);
      lit("m_dec_exe_bubble", int'(dec_exe_bubble), e_bub);
      lit("m_fwd1", int'(fwd_rs1_sel), model_fwd(dec_rs1));
      lit("m_fwd2", int'(fwd_rs2_sel), model_fwd(dec_rs2));
      if (e_ifen == 0 || e_bub == 1) begin
        if (m_stall < SAT) m_stall = m_stall + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dec_valid = 1'b0; dec_rs1 = 5'd0; dec_rs2 = 5'd0;
    dec_uses_rs1 = 1'b0; dec_uses_rs2 = 1'b0;
    exe_valid = 1'b0; exe_rd = 5'd0; exe_regw = 1'b0; exe_memr = 1'b0;
    exe_busy = 1'b0; exe_redirect = 1'b0; mem_rd = 5'd0; mem_regw = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    #1;
    lit("rst_if_id_enable", int'(if_id_enable), 0);
    lit("rst_dec_exe_enable", int'(dec_exe_enable), 0);
    lit("rst_stall_cnt", int'(stall_cnt), 0);
    do_reset();
    tick();

    // Load-use: ld x5 in execute, add reads x5 in decode
    exe_valid = 1'b1; exe_rd = 5'd5; exe_memr = 1'b1; exe_regw = 1'b1;
    dec_valid = 1'b1; dec_rs1 = 5'd5; dec_uses_rs1 = 1'b1; dec_rs2 = 5'd3; dec_uses_rs2 = 1'b1;
    #1;
    lit("lu_if_id_enable", int'(if_id_enable), 0);
    lit("lu_bubble", int'(dec_exe_bubble), 1);
    lit("lu_dec_exe_enable", int'(dec_exe_enable), 1);
    tick();
    exe_valid = 1'b0; exe_memr = 1'b0; exe_regw = 1'b0; exe_rd = 5'd0;
    #1;
    lit("lu_after_enable", int'(if_id_enable), 1);
    lit("lu_after_bubble", int'(dec_exe_bubble), 0);
    lit("lu_stall_cnt", int'(stall_cnt), 1);
    tick();

    // Busy for 4 cycles
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exe_busy = 1'b1;
      #1;
      lit("busy_if_id_enable", int'(if_id_enable), 0);
      lit("busy_dec_exe_enable", int'(dec_exe_enable), 0);
      lit("busy_bubble", int'(dec_exe_bubble), 0);
      tick();
    end
    exe_busy = 1'b0;
    #1;
    lit("busy_stall_cnt", int'(stall_cnt), 4);
    lit("busy_release_enable", int'(if_id_enable), 1);
    tick();

    // Redirect with two squash cycles
    do_reset();
    exe_redirect = 1'b1;
    #1;
    lit("rd_flush_c0", int'(if_id_flush), 1);
    lit("rd_bubble_c0", int'(dec_exe_bubble), 1);
    lit("rd_enable_c0", int'(if_id_enable), 1);
    tick();
    exe_redirect = 1'b0;
    #1;
    lit("rd_flush_c1", int'(if_id_flush), 1);
    lit("rd_flush_cnt", int'(flush_cnt), 1);
    tick();
    #1;
    lit("rd_flush_c2", int'(if_id_flush), 0);
    lit("rd_stall_cnt", int'(stall_cnt), 2);
    tick();

    // Back-to-back redirects reload the squash window
    do_reset();
    exe_redirect = 1'b1;
    tick();
    tick();
    exe_redirect = 1'b0;
    #1;
    lit("rr_flush_tail", int'(if_id_flush), 1);
    lit("rr_flush_cnt", int'(flush_cnt), 2);
    tick();
    tick();

    // Redirect together with load-use: flush wins
    do_reset();
    exe_redirect = 1'b1;
    exe_valid = 1'b1; exe_rd = 5'd9; exe_memr = 1'b1; exe_regw = 1'b1;
    dec_valid = 1'b1; dec_rs2 = 5'd9; dec_uses_rs2 = 1'b1;
    #1;
    lit("rlu_if_id_enable", int'(if_id_enable), 1);
    lit("rlu_flush", int'(if_id_flush), 1);
    tick();
    idle();
    tick();
    tick();

    // Redirect together with busy: hold only
    do_reset();
    exe_redirect = 1'b1; exe_busy = 1'b1;
    #1;
    lit("rb_flush", int'(if_id_flush), 0);
    lit("rb_enable", int'(dec_exe_enable), 0);
    tick();
    idle();
    #1;
    lit("rb_flush_cnt", int'(flush_cnt), 0);
    lit("rb_after_flush", int'(if_id_flush), 0);
    tick();

    // Forwarding
    exe_valid = 1'b1; exe_regw = 1'b1; exe_memr = 1'b0; exe_rd = 5'd7;
    mem_regw = 1'b1; mem_rd = 5'd7; dec_rs1 = 5'd7; dec_rs2 = 5'd7;
    #1;
    lit("fwd_exe_wins", int'(fwd_rs1_sel), 1);
    tick();
    exe_rd = 5'd0; mem_rd = 5'd0; dec_rs1 = 5'd0; dec_rs2 = 5'd0;
    #1;
    lit("fwd_x0", int'(fwd_rs1_sel), 0);
    tick();
    exe_rd = 5'd7; mem_rd = 5'd7; exe_memr = 1'b1; dec_rs1 = 5'd7; dec_rs2 = 5'd4;
    #1;
    lit("fwd_load_mem", int'(fwd_rs1_sel), 2);
    lit("fwd_rs2_none", int'(fwd_rs2_sel), 0);
    tick();
    idle();

    // Reset pulse in the middle of a squash window
    do_reset();
    exe_redirect = 1'b1;
    tick();
    exe_redirect = 1'b0;
    #1;
    lit("rf_in_flush", int'(if_id_flush), 1);
    #1;
    reset = 1'b1;
    #1;
    lit("rf_async_flush", int'(if_id_flush), 0);
    lit("rf_async_bubble", int'(dec_exe_bubble), 0);
    lit("rf_async_enable", int'(if_id_enable), 0);
    lit("rf_async_flush_cnt", int'(flush_cnt), 0);
    lit("rf_async_stall_cnt", int'(stall_cnt), 0);
    tick();
    reset = 1'b0;
    #1;
    lit("rf_run_flush", int'(if_id_flush), 0);
    lit("rf_run_enable", int'(if_id_enable), 1);
    tick();

    // Saturation at 15
    do_reset();
    exe_busy = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    exe_busy = 1'b0;
    #1;
    lit("sat_stall_cnt", int'(stall_cnt), 15);
    exe_redirect = 1'b1;
    for (int i = 0; i < 18; i++) tick();
    exe_redirect = 1'b0;
    #1;
    lit("sat_flush_cnt", int'(flush_cnt), 15);
    tick();
    tick();

    // Mixed traffic, checked by the model only
    do_reset();
    for (int i = 0; i < 300; i++) begin
      exe_busy     = ($urandom_range(0, 5) == 0);
      exe_redirect = ($urandom_range(0, 6) == 0);
      exe_valid    = $urandom_range(0, 1);
      exe_regw     = $urandom_range(0, 1);
      exe_memr     = $urandom_range(0, 1);
      exe_rd       = 5'($urandom_range(0, 3));
      mem_regw     = $urandom_range(0, 1);
      mem_rd       = 5'($urandom_range(0, 3));
      dec_valid    = $urandom_range(0, 1);
      dec_rs1      = 5'($urandom_range(0, 3));
      dec_rs2      = 5'($urandom_range(0, 3));
      dec_uses_rs1 = $urandom_range(0, 1);
      dec_uses_rs2 = $urandom_range(0, 1);
      tick();
    end
    idle();
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
